// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed token transmitter.
package usb_tx_pkg;

    // One state per packet field, plus the two EOP phases.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_ADDR,
        ST_ENDP,
        ST_CRC,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_t;

    // Raw bits per field (before stuffing).
    localparam int SYNC_BITS = 8;
    localparam int PID_BITS  = 8;
    localparam int ADDR_BITS = 7;
    localparam int ENDP_BITS = 4;
    localparam int CRC_BITS  = 5;

    // SYNC as sent LSB first: seven 0s then a 1.
    localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

    // CRC5 = x^5 + x^2 + 1, register seeded with all ones.
    localparam logic [4:0] CRC5_POLY = 5'b00101;
    localparam logic [4:0] CRC5_INIT = 5'b11111;

    // Token PID codes.
    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;

    // Shift one data bit into the CRC5 register (MSB-feedback form).
    function automatic logic [4:0] crc5_next(input logic [4:0] crc, input logic bit_in);
        return {crc[3:0], 1'b0} ^ (((crc[4] ^ bit_in) == 1'b1) ? CRC5_POLY : 5'b00000);
    endfunction

    // Index of the last raw bit of a data field.
    function automatic logic [7:0] last_index(input tx_state_t s);
        case (s)
            ST_SYNC: return 8'(SYNC_BITS - 1);
            ST_PID:  return 8'(PID_BITS - 1);
            ST_ADDR: return 8'(ADDR_BITS - 1);
            ST_ENDP: return 8'(ENDP_BITS - 1);
            ST_CRC:  return 8'(CRC_BITS - 1);
            default: return 8'd0;
        endcase
    endfunction

    // Field that follows a data field.
    function automatic tx_state_t field_after(input tx_state_t s);
        case (s)
            ST_SYNC: return ST_PID;
            ST_PID:  return ST_ADDR;
            ST_ADDR: return ST_ENDP;
            ST_ENDP: return ST_CRC;
            ST_CRC:  return ST_EOP_SE0;
            default: return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/usb_stuff_nrzi_enc.sv
// Bit stuffer and NRZI encoder. Counts consecutive raw 1s, forces a stuffed 0
// (and asks the field FSM to hold) after STUFF_LIMIT of them, and tracks the
// NRZI line level. The line returns to J (1) whenever no packet bits flow.
module usb_stuff_nrzi_enc #(
    parameter int STUFF_LIMIT = 6
) (
    input  logic gclk,
    input  logic reset,
    input  logic data_en,   // a raw field bit is being sent this cycle
    input  logic stuff_en,  // a stuffed 0 may be inserted this cycle
    input  logic raw_bit,
    output logic line,      // line level for this bit time
    output logic hold       // this bit time carries a stuffed 0
);

    localparam int ONES_W = $clog2(STUFF_LIMIT + 1);

    logic [ONES_W-1:0] ones_cnt;
    logic              prev_line;

    // A stuff is due once the run of 1s reaches the limit; a raw 0 or a
    // stuffed 0 toggles the line, a raw 1 holds it.
    assign hold = stuff_en && (ones_cnt == ONES_W'(STUFF_LIMIT));
    assign line = (hold || !raw_bit) ? ~prev_line : prev_line;

    // Advance the ones-counter and line level; park at J outside packets.
    always_ff @(posedge gclk) begin
        if (reset) begin
            prev_line <= 1'b1;
            ones_cnt  <= '0;
        end else if (hold) begin
            prev_line <= line;
            ones_cnt  <= '0;
        end else if (data_en) begin
            prev_line <= line;
            ones_cnt  <= raw_bit ? ones_cnt + ONES_W'(1) : '0;
        end else if (!stuff_en) begin
            prev_line <= 1'b1;
            ones_cnt  <= '0;
        end
    end

endmodule

// File: rtl/usb_token_tx.sv
// USB full-speed token packet transmitter: latches PID/address/endpoint,
// serializes SYNC, PID, ADDR, ENDP, CRC5 and EOP, and drives the bit-stuffed
// NRZI line one bit per gclk.
module usb_token_tx
    import usb_tx_pkg::*;
#(
    parameter int EOP_SE0_BITS = 2,
    parameter int STUFF_LIMIT  = 6
) (
    input  logic       gclk,
    input  logic       reset,
    input  logic       start_txd,
    input  logic [3:0] pid,
    input  logic [6:0] dev_address,
    input  logic [3:0] end_point_address,
    output logic       tx_data_out,
    output logic       tx_se0,
    output logic       tx_data_valid,
    output logic       busy,
    output logic       done
);

    tx_state_t  state, state_nxt;
    logic [7:0] bit_cnt, bit_cnt_nxt;
    logic       done_r;

    logic [3:0] pid_r;
    logic [6:0] addr_r;
    logic [3:0] endp_r;
    logic [4:0] crc_r;
    logic [7:0] pid_byte;

    logic       raw_bit;
    logic       data_en;
    logic       stuff_en;
    logic       hold;
    logic       enc_line;

    assign pid_byte = {~pid_r, pid_r};

    // The state names the bit currently on the line; the stuff window
    // extends into the first EOP_SE0 slot so a stuff owed after CRC lands there.
    assign data_en  = (state == ST_SYNC) || (state == ST_PID) || (state == ST_ADDR) ||
                      (state == ST_ENDP) || (state == ST_CRC);
    assign stuff_en = data_en || (state == ST_EOP_SE0);

    // State, field bit counter and done pulse registers.
    always_ff @(posedge gclk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so the order of statements here does not matter.
        if (reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            done_r  <= (state == ST_EOP_J);
        end
    end

    // Latch the token on accept and run CRC5 over ADDR+ENDP in send order.
    always_ff @(posedge gclk) begin
        // NOTE: these datapath registers carry no reset; they are always
        // loaded on packet accept before anything reads them.
        if (state == ST_IDLE && start_txd) begin
            pid_r  <= pid;
            addr_r <= dev_address;
            endp_r <= end_point_address;
            crc_r  <= CRC5_INIT;
        end else if ((state == ST_ADDR || state == ST_ENDP) && !hold) begin
            crc_r  <= crc5_next(crc_r, raw_bit);
        end
    end

    // Select the raw bit for the current field position (CRC complemented, MSB first).
    always_comb begin
        // NOTE: a default on every path keeps this purely combinational;
        // an unassigned branch would otherwise infer a latch.
        raw_bit = 1'b1;
        case (state)
            ST_SYNC: raw_bit = SYNC_PATTERN[bit_cnt[2:0]];
            ST_PID:  raw_bit = pid_byte[bit_cnt[2:0]];
            ST_ADDR: raw_bit = addr_r[bit_cnt[2:0]];
            ST_ENDP: raw_bit = endp_r[bit_cnt[1:0]];
            ST_CRC:  raw_bit = ~crc_r[3'd4 - bit_cnt[2:0]];
            default: raw_bit = 1'b1;
        endcase
    end

    // Next-state logic: fields advance only on non-stuffed bit times.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        case (state)
            ST_IDLE: begin
                if (start_txd) begin
                    state_nxt   = ST_SYNC;
                    bit_cnt_nxt = '0;
                end
            end
            ST_SYNC, ST_PID, ST_ADDR, ST_ENDP, ST_CRC: begin
                if (!hold) begin
                    if (bit_cnt == last_index(state)) begin
                        state_nxt   = field_after(state);
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 8'd1;
                    end
                end
            end
            ST_EOP_SE0: begin
                if (!hold) begin
                    if (bit_cnt == 8'(EOP_SE0_BITS - 1)) begin
                        state_nxt   = ST_EOP_J;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 8'd1;
                    end
                end
            end
            ST_EOP_J: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    usb_stuff_nrzi_enc #(
        .STUFF_LIMIT(STUFF_LIMIT)
    ) u_enc (
        .gclk    (gclk),
        .reset   (reset),
        .data_en (data_en),
        .stuff_en(stuff_en),
        .raw_bit (raw_bit),
        .line    (enc_line),
        .hold    (hold)
    );

    // Line drivers: J when idle or in EOP_J, SE0 during EOP, NRZI otherwise.
    always_comb begin
        tx_data_out = 1'b1;
        tx_se0      = 1'b0;
        case (state)
            ST_IDLE, ST_EOP_J: tx_data_out = 1'b1;
            ST_EOP_SE0: begin
                if (hold) begin
                    tx_data_out = enc_line;
                end else begin
                    tx_data_out = 1'b0;
                    tx_se0      = 1'b1;
                end
            end
            default: tx_data_out = enc_line;
        endcase
    end

    assign busy          = (state != ST_IDLE);
    assign tx_data_valid = busy;
    assign done          = done_r;

endmodule

// File: tb/tb_usb_token_tx.sv
// Directed and random-token bench for usb_token_tx with an NRZI/destuff
// decoder that recovers the packet fields from the line.
module tb_usb_token_tx;
    import usb_tx_pkg::*;

    localparam int MAX_BITS = 200;

    logic       gclk = 1'b0;
    logic       reset;
    logic       start_txd;
    logic [3:0] pid;
    logic [6:0] dev_address;
    logic [3:0] end_point_address;
    logic       tx_data_out;
    logic       tx_se0;
    logic       tx_data_valid;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    // Captured packet
    logic line_q [0:255];
    logic se0_q  [0:255];
    int   nb;
    int   done_early;

    // Decoded packet
    logic       dbits [0:39];
    logic [7:0] d_sync, d_pid, d_b1, d_b2;
    logic [6:0] d_addr;
    logic [3:0] d_ep;
    logic [4:0] d_crc;
    int         d_stuff, d_se0, d_serr, d_ndata;
    logic       d_jok;

    usb_token_tx dut (
        .gclk             (gclk),
        .reset            (reset),
        .start_txd        (start_txd),
        .pid              (pid),
        .dev_address      (dev_address),
        .end_point_address(end_point_address),
        .tx_data_out      (tx_data_out),
        .tx_se0           (tx_se0),
        .tx_data_valid    (tx_data_valid),
        .busy             (busy),
        .done             (done)
    );

    always #5 gclk = ~gclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC5 in the reflected (LSB-first) form; returns the field
    // with bit 0 being the first bit on the wire.
    function automatic logic [4:0] ref_crc5(input logic [6:0] a, input logic [3:0] e);
        logic [10:0] tok;
        logic [4:0]  c;
        tok = {e, a};
        c   = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            if ((c[0] ^ tok[i]) == 1'b1) c = (c >> 1) ^ 5'h14;
            else                         c = c >> 1;
        end
        return ~c;
    endfunction

    // Expected bit times on the line, including stuffed bits and EOP.
    function automatic int model_len(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e);
        logic [31:0] bits;
        int ones, s;
        bits = {ref_crc5(a, e), e, a, ~p, p, 8'h80};
        ones = 0;
        s    = 0;
        for (int i = 0; i < 32; i++) begin
            if (bits[i]) ones++;
            else         ones = 0;
            if (ones == 6) begin
                s++;
                ones = 0;
            end
        end
        return 32 + s + 2 + 1;
    endfunction

    // Sample one packet at negedges until tx_data_valid drops.
    task automatic capture(input int poke_at, input bit restart,
                           input logic [3:0] np, input logic [6:0] na, input logic [3:0] ne);
        nb = 0;
        done_early = 0;
        while (tx_data_valid && nb < MAX_BITS) begin
            line_q[nb] = tx_data_out;
            se0_q[nb]  = tx_se0;
            if (done) done_early++;
            if (nb == poke_at) begin
                start_txd         = 1'b1;
                pid               = ~pid;
                dev_address       = ~dev_address;
                end_point_address = ~end_point_address;
            end else begin
                start_txd = 1'b0;
            end
            nb++;
            @(negedge gclk);
        end
        check("no_timeout", nb < MAX_BITS, 1);
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        check("done_early", done_early, 0);
        if (restart) begin
            pid               = np;
            dev_address       = na;
            end_point_address = ne;
            start_txd         = 1'b1;
        end
    endtask

    task automatic send(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                        input int poke_at, input bit restart,
                        input logic [3:0] np, input logic [6:0] na, input logic [3:0] ne);
        pid               = p;
        dev_address       = a;
        end_point_address = e;
        start_txd         = 1'b1;
        @(negedge gclk);
        start_txd = 1'b0;
        capture(poke_at, restart, np, na, ne);
        if (!restart) begin
            @(negedge gclk);
            check("done_width", done, 0);
        end
    endtask

    // NRZI-decode, destuff and split the captured packet into fields.
    task automatic decode();
        logic prev, r;
        int ones, k, i;
        for (int j = 0; j < 40; j++) dbits[j] = 1'b0;
        prev = 1'b1; ones = 0; k = 0; i = 0;
        d_stuff = 0; d_serr = 0; d_se0 = 0;
        while (i < nb && !se0_q[i]) begin
            r    = (line_q[i] == prev);
            prev = line_q[i];
            if (ones == 6) begin
                d_stuff++;
                if (r) d_serr++;
                ones = 0;
            end else begin
                if (k < 40) dbits[k] = r;
                k++;
                ones = r ? ones + 1 : 0;
            end
            i++;
        end
        d_ndata = k;
        while (i < nb && se0_q[i]) begin
            if (line_q[i] != 1'b0) d_serr++;
            d_se0++;
            i++;
        end
        d_jok = (i == nb - 1) && (line_q[i] == 1'b1) && !se0_q[i];
        for (int j = 0; j < 8; j++) begin
            d_sync[j] = dbits[j];
            d_pid[j]  = dbits[8 + j];
            d_b1[j]   = dbits[16 + j];
            d_b2[j]   = dbits[24 + j];
        end
        for (int j = 0; j < 7; j++) d_addr[j] = dbits[16 + j];
        for (int j = 0; j < 4; j++) d_ep[j]   = dbits[23 + j];
        for (int j = 0; j < 5; j++) d_crc[j]  = dbits[27 + j];
    endtask

    task automatic check_token(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e);
        decode();
        check("sync", d_sync, 8'h80);
        check("pid_byte", d_pid, {~p, p});
        check("addr", d_addr, a);
        check("endp", d_ep, e);
        check("crc5", d_crc, ref_crc5(a, e));
        check("data_bits", d_ndata, 32);
        check("stuff_ok", d_serr, 0);
        check("se0_bits", d_se0, 2);
        check("eop_j", d_jok, 1);
        check("pkt_len", nb, model_len(p, a, e));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int run, idle_bad;
        logic [3:0] rp, re;
        logic [6:0] ra;

        reset = 1'b1; start_txd = 1'b0;
        pid = '0; dev_address = '0; end_point_address = '0;
        repeat (3) @(negedge gclk);
        check("rst_line", tx_data_out, 1);
        check("rst_se0", tx_se0, 0);
        check("rst_valid", tx_data_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        @(negedge gclk);

        // SETUP to address 0, endpoint 0: no stuffing, 35 bit times.
        send(PID_SETUP, 7'h00, 4'h0, -1, 1'b0, 4'h0, 7'h00, 4'h0);
        decode();
        check("setup_first_line", line_q[0], 0);
        check("setup_sync", d_sync, 8'h80);
        check("setup_pid", d_pid, 8'h2D);
        check("setup_b1", d_b1, 8'h00);
        check("setup_b2", d_b2, 8'h10);
        check("setup_crc", d_crc, 5'b00010);
        check("setup_stuff", d_stuff, 0);
        check("setup_len", nb, 35);
        check("setup_se0", d_se0, 2);

        // IN to 7F/F: six ADDR 1s hold the line, then a stuffed toggle.
        send(PID_IN, 7'h7F, 4'hF, -1, 1'b0, 4'h0, 7'h00, 4'h0);
        run = 0;
        for (int j = 16; j < nb; j++) begin
            if (line_q[j] != line_q[15]) break;
            run++;
        end
        check("in_addr_hold", run, 6);
        check_token(PID_IN, 7'h7F, 4'hF);
        check("in_stuff", d_stuff, 1);
        check("in_len", nb, 36);

        // start_txd mid-packet (with inputs changing) is ignored and not queued.
        send(PID_OUT, 7'h15, 4'h3, 12, 1'b0, 4'h0, 7'h00, 4'h0);
        check_token(PID_OUT, 7'h15, 4'h3);
        idle_bad = 0;
        repeat (4) begin
            @(negedge gclk);
            if (busy) idle_bad++;
        end
        check("no_queue", idle_bad, 0);

        // start_txd in the done cycle starts the next packet right away.
        send(PID_SOF, 7'h2A, 4'h6, -1, 1'b1, PID_OUT, 7'h01, 4'h9);
        check_token(PID_SOF, 7'h2A, 4'h6);
        @(negedge gclk);
        start_txd = 1'b0;
        check("restart_valid", tx_data_valid, 1);
        check("restart_line", tx_data_out, 0);
        capture(-1, 1'b0, 4'h0, 7'h00, 4'h0);
        check_token(PID_OUT, 7'h01, 4'h9);
        @(negedge gclk);

        // Reset during CRC abandons the packet.
        pid = PID_SETUP; dev_address = 7'h00; end_point_address = 4'h0;
        start_txd = 1'b1;
        @(negedge gclk);
        start_txd = 1'b0;
        repeat (28) @(negedge gclk);
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        @(negedge gclk);
        check("midrst_line", tx_data_out, 1);
        check("midrst_se0", tx_se0, 0);
        check("midrst_valid", tx_data_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        reset = 1'b0;
        @(negedge gclk);
        check("postrst_done", done, 0);
        send(PID_SETUP, 7'h00, 4'h0, -1, 1'b0, 4'h0, 7'h00, 4'h0);
        decode();
        check("rst_setup_pid", d_pid, 8'h2D);
        check("rst_setup_b1", d_b1, 8'h00);
        check("rst_setup_b2", d_b2, 8'h10);
        check("rst_setup_len", nb, 35);

        // Random tokens through the decoder loopback.
        for (int t = 0; t < 100; t++) begin
            rp = 4'($urandom);
            ra = 7'($urandom);
            re = 4'($urandom);
            send(rp, ra, re, -1, 1'b0, 4'h0, 7'h00, 4'h0);
            check_token(rp, ra, re);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_token_tx.md
# usb_token_tx

Transmit-side token packet generator for the USB 2.0 full-speed path. It latches a PID, device address and endpoint, then serializes SYNC, PID, ADDR, ENDP, CRC5 and EOP one bit per `gclk`. The raw stream is bit-stuffed and NRZI-encoded, so `tx_data_out` is the line-level stream the NRZI decoder and packet-field receiver consume. It is the transmit counterpart of that receiver.

## Interface
Parameters:
- `EOP_SE0_BITS`, 2: number of SE0 bit times in EOP.
- `STUFF_LIMIT`, 6: run of consecutive raw 1s after which a 0 is inserted.

Ports:
- `gclk`  in  1  bit-rate clock; the design has one clock.
- `reset`  in  1  synchronous, active-high reset.
- `start_txd`  in  1  request to send; sampled only while `busy`=0.
- `pid`  in  4  PID code; the PID byte is {~pid, pid}.
- `dev_address`  in  7  device address.
- `end_point_address`  in  4  endpoint number.
- `tx_data_out`  out  1  NRZI line bit (1 = J/idle).
- `tx_se0`  out  1  high during EOP SE0 bit times.
- `tx_data_valid`  out  1  high for every packet bit time, SYNC through EOP J.
- `busy`  out  1  packet in progress.
- `done`  out  1  one-cycle pulse after the EOP J bit.

## Operation
- FSM states: IDLE, SYNC, PID, ADDR, ENDP, CRC, EOP_SE0, EOP_J.
  - IDLE→SYNC when `start_txd`=1. `pid`, `dev_address` and `end_point_address` are latched on that edge.
  - SYNC(8)→PID(8)→ADDR(7)→ENDP(4)→CRC(5)→EOP_SE0(`EOP_SE0_BITS`)→EOP_J(1)→IDLE. Numbers are raw bits per state.
- SYNC raw bits are 0,0,0,0,0,0,0,1.
- All fields except CRC are sent LSB first.
- CRC5:
  - Polynomial x^5+x^2+1, register initialised to 5'b11111.
  - The register is updated with the 11 ADDR+ENDP bits in transmit order.
  - The complement of the register is sent, register bit 4 first.
- Bit stuffing:
  - The ones-counter counts consecutive raw 1s from SYNC through the last CRC bit, continuing across field boundaries.
  - When the count reaches `STUFF_LIMIT`, the next bit time carries a raw 0, the field bit counter holds, and the ones-counter clears.
  - A stuff due after the last CRC bit is inserted before EOP.
- NRZI: raw 0 toggles the line and raw 1 holds it. The line value holds at 1 in IDLE.
- EOP:
  - During EOP_SE0, `tx_se0`=1 and `tx_data_out`=0.
  - During EOP_J, `tx_data_out`=1 and `tx_se0`=0.
  - The NRZI line state resets to 1 for the next packet.
- `start_txd` while `busy`=1 is ignored and is not queued.

## Timing
- Reset values: `tx_data_out`=1, `tx_se0`=0, `tx_data_valid`=0, `busy`=0, `done`=0, FSM in IDLE, ones-counter=0.
- `start_txd`=1 sampled at edge N (IDLE):
  - After edge N, `busy`=1, `tx_data_valid`=1, and `tx_data_out` carries the first SYNC bit (0), i.e. the line toggles 1→0.
  - One new line bit is driven per edge after that.
- Packet length is 32 + S + `EOP_SE0_BITS` + 1 bit times, where S is the number of stuffed bits. With no stuffing and default parameters this is 35.
- After the last EOP_J edge, `done`=1 for one cycle and `busy`=0, `tx_data_valid`=0 in the same cycle.
- `start_txd` in that `done` cycle is accepted.
- `reset` mid-packet: the next cycle has all outputs at reset values, no `done` pulse, and the partial packet is abandoned.

## Structure
- Package `usb_tx_pkg` holds:
  - the FSM state enum;
  - the field-length constants (8/8/7/4/5);
  - the SYNC pattern;
  - the CRC5 polynomial and init value;
  - PID codes (OUT=4'h1, IN=4'h9, SOF=4'h5, SETUP=4'hD).
- Sub-module `usb_stuff_nrzi_enc` takes the raw bit plus a stuff-enable input. It holds the ones-counter and NRZI line register, and returns a hold/stall signal to the field FSM.
- Top level: FSM, field shift registers and the CRC5 register.

## Test plan
- SETUP, address 0, endpoint 0 → raw bytes after SYNC are 0x2D, 0x00, 0x10 (CRC5 field 5'b00010). S=0, 35 valid cycles, one `done` pulse.
- IN (pid 4'h9), address 7'h7F, endpoint 4'hF:
  - After the 6th consecutive ADDR 1, the line holds for exactly 6 bit times, then toggles (stuffed 0).
  - The total bit count equals the reference-model count.
- `start_txd` pulsed mid-packet → the packet is unchanged and no second packet starts. A pulse in the `done` cycle starts a new SYNC the next cycle.
- `reset` asserted during CRC → next cycle `tx_data_out`=1, `busy`=0, no `done`. A following SETUP to address 0 endpoint 0 transmits correctly.
- A decoder loopback checks the raw stream recovered through the NRZI decoder and packet-field receiver against `pid`/`dev_address`/`end_point_address` for 100 random tokens. `tx_se0` is high for exactly 2 cycles per packet.
